// File: rtl/clock_lose_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : clock_lose_ctrl
// Purpose  : Supervises a bank of clock_check channels. Distributes a
//            configurable threshold to the checkers, sequences each checker
//            through reset/holdoff/monitor/recovery, raises sticky loss
//            alarms and performs non-revertive selection of a healthy clock.
// Ports    : I_reference_clk   - sole clock, rising edge
//            I_reset           - asynchronous active-high reset
//            I_clock_lose      - per-channel loss flag (reference domain)
//            I_enable          - per-channel supervision enable (level)
//            I_cfg_load        - strobe latching the three cfg_* inputs
//            I_cfg_parameter   - checker threshold to distribute
//            I_cfg_holdoff     - settle cycles after start / reconfiguration
//            I_cfg_recover     - clean cycles needed to re-qualify a channel
//            I_alarm_clear     - strobe clearing the sticky alarms
//            O_clock_parameter - registered threshold to all checkers
//            O_checker_reset_n - active-low reset to each checker
//            O_alarm           - per-channel sticky loss alarm
//            O_active_sel      - index of the selected healthy clock
//            O_switch_pulse    - one-cycle pulse on every O_active_sel change
//            O_all_lost        - no channel currently healthy
// Revision : 1.0 - initial release
// ============================================================================
module clock_lose_ctrl #(
    parameter int CH_NUM = 4
) (
    input  logic              I_reference_clk,
    input  logic              I_reset,
    input  logic [CH_NUM-1:0] I_clock_lose,
    input  logic [CH_NUM-1:0] I_enable,
    input  logic              I_cfg_load,
    input  logic [4:0]        I_cfg_parameter,
    input  logic [7:0]        I_cfg_holdoff,
    input  logic [7:0]        I_cfg_recover,
    input  logic              I_alarm_clear,
    output logic [4:0]        O_clock_parameter,
    output logic [CH_NUM-1:0] O_checker_reset_n,
    output logic [CH_NUM-1:0] O_alarm,
    output logic [1:0]        O_active_sel,
    output logic              O_switch_pulse,
    output logic              O_all_lost
);

    localparam int SEL_W = 2;

    localparam logic [4:0] PARAM_RST   = 5'd16;
    localparam logic [7:0] HOLDOFF_RST = 8'd32;
    localparam logic [7:0] RECOVER_RST = 8'd64;

    typedef enum logic [2:0] {
        ST_DISABLED = 3'd0,
        ST_HOLDOFF  = 3'd1,
        ST_MONITOR  = 3'd2,
        ST_LOST     = 3'd3,
        ST_RECOVER  = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // Input retiming and configuration latch
    // ------------------------------------------------------------------
    logic [CH_NUM-1:0] lose_q;
    logic [4:0]        param_q;
    logic [7:0]        holdoff_q;
    logic [7:0]        recover_q;

    always_ff @(posedge I_reference_clk or posedge I_reset) begin
        if (I_reset) begin
            lose_q    <= '0;
            param_q   <= PARAM_RST;
            holdoff_q <= HOLDOFF_RST;
            recover_q <= RECOVER_RST;
        end else begin
            lose_q <= I_clock_lose;
            if (I_cfg_load) begin
                param_q   <= I_cfg_parameter;
                holdoff_q <= I_cfg_holdoff;
                recover_q <= I_cfg_recover;
            end
        end
    end

    assign O_clock_parameter = param_q;

    // ------------------------------------------------------------------
    // Per-channel supervision FSM
    // ------------------------------------------------------------------
    logic [CH_NUM-1:0] w_healthy;

    for (genvar gi = 0; gi < CH_NUM; gi++) begin : g_ch
        state_t     state_q;
        logic [7:0] cnt_q;
        logic       alarm_q;
        logic       chk_rst_n_q;
        logic [7:0] w_cnt_inc;

        // Saturating increment; the compare against holdoff/recover always
        // fires first, so saturation only guards against wrap.
        assign w_cnt_inc = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;

        always_ff @(posedge I_reference_clk or posedge I_reset) begin
            if (I_reset) begin
                state_q     <= ST_DISABLED;
                cnt_q       <= '0;
                alarm_q     <= 1'b0;
                chk_rst_n_q <= 1'b0;
            end else begin
                // An enabled channel is never DISABLED on the next cycle, so
                // the checker reset simply follows the registered enable.
                chk_rst_n_q <= I_enable[gi];

                // Clear first; a set later in this block overrides it.
                if (I_alarm_clear) begin
                    alarm_q <= 1'b0;
                end

                if (!I_enable[gi]) begin
                    state_q <= ST_DISABLED;
                    cnt_q   <= '0;
                end else if (I_cfg_load) begin
                    state_q <= ST_HOLDOFF;
                    cnt_q   <= '0;
                end else begin
                    case (state_q)
                        ST_DISABLED: begin
                            state_q <= ST_HOLDOFF;
                            cnt_q   <= '0;
                        end
                        ST_HOLDOFF: begin
                            // Loss flags are ignored while the checker settles.
                            if (cnt_q == holdoff_q) begin
                                state_q <= ST_MONITOR;
                            end else begin
                                cnt_q <= w_cnt_inc;
                            end
                        end
                        ST_MONITOR: begin
                            if (lose_q[gi]) begin
                                state_q <= ST_LOST;
                                alarm_q <= 1'b1;
                            end
                        end
                        ST_LOST: begin
                            if (!lose_q[gi]) begin
                                state_q <= ST_RECOVER;
                                cnt_q   <= '0;
                            end
                        end
                        ST_RECOVER: begin
                            if (lose_q[gi]) begin
                                state_q <= ST_LOST;
                                alarm_q <= 1'b1;
                            end else if (cnt_q == recover_q) begin
                                state_q <= ST_MONITOR;
                            end else begin
                                cnt_q <= w_cnt_inc;
                            end
                        end
                        default: begin
                            state_q <= ST_DISABLED;
                            cnt_q   <= '0;
                        end
                    endcase
                end
            end
        end

        assign w_healthy[gi]         = (state_q == ST_MONITOR);
        assign O_alarm[gi]           = alarm_q;
        assign O_checker_reset_n[gi] = chk_rst_n_q;
    end

    // ------------------------------------------------------------------
    // Non-revertive clock selection
    // ------------------------------------------------------------------
    logic [SEL_W-1:0] w_low_idx;
    logic             w_found;
    logic [SEL_W-1:0] sel_d;
    logic [SEL_W-1:0] sel_q;
    logic             pulse_d;
    logic             pulse_q;
    logic             all_lost_d;
    logic             all_lost_q;

    always_comb begin
        w_low_idx = '0;
        w_found   = 1'b0;
        for (int i = 0; i < CH_NUM; i++) begin
            if (w_healthy[i] && !w_found) begin
                w_low_idx = i[SEL_W-1:0];
                w_found   = 1'b1;
            end
        end
    end

    always_comb begin
        sel_d      = sel_q;
        pulse_d    = 1'b0;
        all_lost_d = !w_found;
        // Only move away from the current clock when it is no longer
        // healthy; a recovered lower-index clock does not pull selection back.
        if (w_found && !w_healthy[sel_q]) begin
            sel_d   = w_low_idx;
            pulse_d = 1'b1;
        end
    end

    always_ff @(posedge I_reference_clk or posedge I_reset) begin
        if (I_reset) begin
            sel_q      <= '0;
            pulse_q    <= 1'b0;
            all_lost_q <= 1'b1;
        end else begin
            sel_q      <= sel_d;
            pulse_q    <= pulse_d;
            all_lost_q <= all_lost_d;
        end
    end

    assign O_active_sel   = sel_q;
    assign O_switch_pulse = pulse_q;
    assign O_all_lost     = all_lost_q;

endmodule
`default_nettype wire

// File: tb/tb_clock_lose_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_clock_lose_ctrl
// Purpose  : Directed self-checking bench for clock_lose_ctrl. Inputs change
//            1 time unit after each rising edge; outputs are sampled at the
//            same point, i.e. away from the active edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_clock_lose_ctrl;

    logic       clk;
    logic       rst;
    logic [3:0] clock_lose;
    logic [3:0] enable;
    logic       cfg_load;
    logic [4:0] cfg_parameter;
    logic [7:0] cfg_holdoff;
    logic [7:0] cfg_recover;
    logic       alarm_clear;
    logic [4:0] clock_parameter;
    logic [3:0] checker_reset_n;
    logic [3:0] alarm;
    logic [1:0] active_sel;
    logic       switch_pulse;
    logic       all_lost;

    int n_assert = 0;
    int n_fail   = 0;

    clock_lose_ctrl #(.CH_NUM(4)) u_dut (
        .I_reference_clk   (clk),
        .I_reset           (rst),
        .I_clock_lose      (clock_lose),
        .I_enable          (enable),
        .I_cfg_load        (cfg_load),
        .I_cfg_parameter   (cfg_parameter),
        .I_cfg_holdoff     (cfg_holdoff),
        .I_cfg_recover     (cfg_recover),
        .I_alarm_clear     (alarm_clear),
        .O_clock_parameter (clock_parameter),
        .O_checker_reset_n (checker_reset_n),
        .O_alarm           (alarm),
        .O_active_sel      (active_sel),
        .O_switch_pulse    (switch_pulse),
        .O_all_lost        (all_lost)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_assert++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst           = 1'b1;
        clock_lose    = 4'b0000;
        enable        = 4'b0000;
        cfg_load      = 1'b0;
        cfg_parameter = 5'd0;
        cfg_holdoff   = 8'd0;
        cfg_recover   = 8'd0;
        alarm_clear   = 1'b0;

        // ---------------- reset state ----------------
        tick(2);
        check_eq("rst_param",    clock_parameter, 5'd16);
        check_eq("rst_chk_rstn", checker_reset_n, 4'b0000);
        check_eq("rst_alarm",    alarm,           4'b0000);
        check_eq("rst_sel",      active_sel,      2'd0);
        check_eq("rst_pulse",    switch_pulse,    1'b0);
        check_eq("rst_all_lost", all_lost,        1'b1);

        // ---------------- channel 0 start, holdoff 32 ----------------
        rst    = 1'b0;
        enable = 4'b0001;
        tick(1);                                   // E0: HOLDOFF
        check_eq("start_chk_rstn", checker_reset_n, 4'b0001);
        check_eq("start_all_lost", all_lost, 1'b1);
        tick(33);                                  // E33: MONITOR entered
        check_eq("hold33_all_lost", all_lost, 1'b1);
        tick(1);                                   // E34
        check_eq("hold34_all_lost", all_lost, 1'b0);
        check_eq("hold34_sel",      active_sel, 2'd0);
        check_eq("hold34_pulse",    switch_pulse, 1'b0);

        // ---------------- reconfiguration during MONITOR ----------------
        enable        = 4'b0011;
        cfg_load      = 1'b1;
        cfg_parameter = 5'd9;
        cfg_holdoff   = 8'd3;
        cfg_recover   = 8'd64;
        tick(1);                                   // C: both HOLDOFF
        cfg_load = 1'b0;
        check_eq("cfg_param", clock_parameter, 5'd9);
        clock_lose = 4'b0001;                      // loss seen only inside holdoff
        tick(1);                                   // C+1
        check_eq("cfg_all_lost", all_lost, 1'b1);
        check_eq("cfg_sel_hold", active_sel, 2'd0);
        tick(1);                                   // C+2
        clock_lose = 4'b0000;
        tick(1);                                   // C+3
        check_eq("holdoff_no_alarm_a", alarm, 4'b0000);
        tick(1);                                   // C+4: MONITOR
        check_eq("holdoff_no_alarm_b", alarm, 4'b0000);
        check_eq("cfg_all_lost_b", all_lost, 1'b1);
        tick(1);                                   // C+5
        check_eq("holdoff_no_alarm_c", alarm, 4'b0000);
        check_eq("cfg_all_lost_c", all_lost, 1'b0);
        check_eq("cfg_sel_c", active_sel, 2'd0);

        // ---------------- ch0 loss, switch to ch1 ----------------
        clock_lose = 4'b0001;
        tick(1);                                   // N: lose_q set
        check_eq("lose_N_alarm", alarm, 4'b0000);
        tick(1);                                   // N+1
        check_eq("lose_N1_alarm", alarm, 4'b0001);
        check_eq("lose_N1_sel",   active_sel, 2'd0);
        check_eq("lose_N1_pulse", switch_pulse, 1'b0);
        tick(1);                                   // N+2
        check_eq("lose_N2_sel",   active_sel, 2'd1);
        check_eq("lose_N2_pulse", switch_pulse, 1'b1);
        tick(1);                                   // N+3
        check_eq("lose_N3_pulse", switch_pulse, 1'b0);
        tick(1);                                   // N+4
        clock_lose = 4'b0000;                      // ch0 RECOVER from N+6

        // ---------------- alarm clear ----------------
        tick(6);                                   // N+10
        alarm_clear = 1'b1;
        tick(1);                                   // N+11
        alarm_clear = 1'b0;
        check_eq("clear_alarm", alarm, 4'b0000);

        // ---------------- glitch restarts recovery count ----------------
        tick(33);                                  // N+44
        clock_lose = 4'b0001;
        tick(1);                                   // G = N+45: lose_q pulse
        clock_lose = 4'b0000;
        tick(1);                                   // G+1: back to LOST
        check_eq("glitch_alarm", alarm, 4'b0001);
        tick(63);                                  // G+64
        clock_lose = 4'b0010;                      // ch1 LOST at G+66
        tick(2);                                   // G+66
        check_eq("g66_sel",      active_sel, 2'd1);
        check_eq("g66_all_lost", all_lost, 1'b0);
        tick(1);                                   // G+67: ch0 MONITOR now
        check_eq("g67_all_lost", all_lost, 1'b1);
        check_eq("g67_sel",      active_sel, 2'd1);
        check_eq("g67_pulse",    switch_pulse, 1'b0);
        check_eq("g67_alarm",    alarm, 4'b0011);
        tick(1);                                   // G+68
        check_eq("g68_all_lost", all_lost, 1'b0);
        check_eq("g68_sel",      active_sel, 2'd0);
        check_eq("g68_pulse",    switch_pulse, 1'b1);
        tick(1);                                   // G+69
        check_eq("g69_pulse",    switch_pulse, 1'b0);

        // ---------------- all lost; clear collides with new set ----------------
        clock_lose = 4'b0011;
        tick(1);                                   // G+70
        alarm_clear = 1'b1;
        tick(1);                                   // G+71: ch0 LOST, set wins
        alarm_clear = 1'b0;
        check_eq("clr_vs_set_alarm", alarm, 4'b0001);
        tick(1);                                   // G+72
        check_eq("all_lost_flag",  all_lost, 1'b1);
        check_eq("all_lost_sel",   active_sel, 2'd0);
        check_eq("all_lost_pulse", switch_pulse, 1'b0);
        tick(1);                                   // G+73
        check_eq("all_lost_pulse_b", switch_pulse, 1'b0);

        // ---------------- disable ch1 while LOST ----------------
        enable = 4'b0001;
        tick(1);                                   // G+74
        check_eq("dis1_chk_rstn", checker_reset_n, 4'b0001);
        check_eq("dis1_alarm",    alarm, 4'b0001);

        // ---------------- mid-operation asynchronous reset ----------------
        clock_lose = 4'b0000;
        #2;
        rst = 1'b1;
        #1;
        check_eq("mid_rst_chk_rstn", checker_reset_n, 4'b0000);
        check_eq("mid_rst_alarm",    alarm, 4'b0000);
        check_eq("mid_rst_all_lost", all_lost, 1'b1);
        check_eq("mid_rst_param",    clock_parameter, 5'd16);
        check_eq("mid_rst_pulse",    switch_pulse, 1'b0);
        tick(2);
        rst = 1'b0;
        tick(1);                                   // E0: HOLDOFF, default 32
        check_eq("re_chk_rstn", checker_reset_n, 4'b0001);
        tick(33);                                  // E33
        check_eq("re33_all_lost", all_lost, 1'b1);
        tick(1);                                   // E34
        check_eq("re34_all_lost", all_lost, 1'b0);
        check_eq("re34_sel",      active_sel, 2'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
